led_frame_scheduler: RTL

- Sits between the UART receiver and FourDigitLEDdriver.
- Assembles pairs of received bytes into 16-bit display words (4 nibble codes) and drives the driver's 16-bit data input.
- Enforces a minimum on-screen hold time per word and queues one pending word.
- Handles receive errors and inter-byte timeouts.

---
 rtl/led_frame_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: pairs received UART bytes into 16-bit display words for
// FourDigitLEDdriver, keeps each word on screen for a minimum hold time, and
// holds at most one pending word. Receive errors and inter-byte timeouts
// discard the partial frame. Errors also show the all-dashes pattern.
//
// Byte input: rx_data/rx_ferror/rx_perror are meaningful only in a cycle with
// rx_valid=1. There is no backpressure, so every strobe is consumed.
module led_frame_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter logic [15:0] BLANK_CODE     = 16'hCCCC,
   parameter logic [15:0] ERR_CODE       = 16'hAAAA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_ferror,
   input  logic        rx_perror,
   output logic [15:0] led_data,
   output logic        frame_done,
   output logic        frame_err,
   output logic        overrun,
   output logic        busy
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] HOLD_MAX = 16'(HOLD_CYCLES);

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] tmo_q, tmo_d;
   logic        pend_valid_q, pend_valid_d;
   logic [15:0] pend_word_q, pend_word_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] led_q, led_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        ovr_q, ovr_d;
   logic        busy_q, busy_d;

   logic        rx_err;
   logic        offer;
   logic [15:0] offer_word;
   logic        load;

   assign rx_err = rx_ferror | rx_perror;

   // State register: all state and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_HI;
         hi_q         <= '0;
         tmo_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_word_q  <= '0;
         hold_q       <= HOLD_MAX;
         led_q        <= BLANK_CODE;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ovr_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         tmo_q        <= tmo_d;
         pend_valid_q <= pend_valid_d;
         pend_word_q  <= pend_word_d;
         hold_q       <= hold_d;
         led_q        <= led_d;
         done_q       <= done_d;
         err_q        <= err_d;
         ovr_q        <= ovr_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic: byte pairing, error discard and WAIT_LO timeout.
   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      tmo_d      = tmo_q;
      offer      = 1'b0;
      offer_word = ERR_CODE;
      err_d      = 1'b0;
      case (state_q)
         WAIT_HI: begin
            if (rx_valid) begin
               if (rx_err) begin
                  offer = 1'b1;
                  err_d = 1'b1;
               end else begin
                  hi_d    = rx_data;
                  tmo_d   = '0;
                  state_d = WAIT_LO;
               end
            end
         end
         WAIT_LO: begin
            if (rx_valid) begin
               state_d = WAIT_HI;
               offer   = 1'b1;
               if (rx_err) begin
                  err_d = 1'b1;
               end else begin
                  offer_word = {hi_q, rx_data};
               end
            end else if (tmo_q == TMO_LAST) begin
               // Second byte never came: drop the high byte, display untouched.
               state_d = WAIT_HI;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         default: state_d = WAIT_HI;
      endcase
   end

   // Output logic: pending slot, hold counter and display load.
   always_comb begin
      load = pend_valid_q && (hold_q == HOLD_MAX);
      led_d  = load ? pend_word_q : led_q;
      done_d = load;
      if (load) begin
         hold_d = '0;
      end else if (hold_q < HOLD_MAX) begin
         hold_d = hold_q + 16'd1;
      end else begin
         hold_d = hold_q;
      end
      // An offer in the same cycle as a load refills the slot without overrun.
      pend_valid_d = offer ? 1'b1 : (load ? 1'b0 : pend_valid_q);
      pend_word_d  = offer ? offer_word : pend_word_q;
      ovr_d        = offer && pend_valid_q && !load;
      busy_d       = (state_d == WAIT_LO);
   end

   assign led_data   = led_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign overrun    = ovr_q;
   assign busy       = busy_q;

endmodule
